fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param_if.sv | 38 +++
 rtl/fifo_param.sv | 121 ++++++++++++
 tb/tb_fifo_param.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// FIFO access bundle: write/read requests from the user side, data and
// status back from the FIFO.
//
// Handshake: a write is taken on any rising edge where wr_en=1 and the FIFO
// is not full (or is full but a read is taken on the same edge). A read is
// taken on any rising edge where rd_en=1 and the FIFO is not empty. There is
// no stall; wr_ack/overflow/underflow report the outcome one cycle later.
interface fifo_param_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CNT_W-1:0]      count;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/fifo_param.sv
// Single-clock synchronous FIFO with arbitrary depth, registered or
// first-word-fall-through read data, and one-cycle-late write/read outcome flags.
module fifo_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1,
  parameter int FWFT       = 0
) (
  input  logic         clk,
  input  logic         rst,
  fifo_param_if.slave  bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL    = CNT_W'(FIFO_DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] AE_LVL    = CNT_W'(AE_MARGIN);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ack_q, wr_ack_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic full, empty, almostfull, almostempty;
  logic rd_accept, wr_accept;

  // Status flags decoded purely from the registered occupancy.
  always_comb begin
    full        = (count_q == DEPTH_CNT);
    empty       = (count_q == '0);
    almostfull  = (count_q >= AF_LVL) && !full;
    almostempty = (count_q <= AE_LVL) && !empty;
  end

  // Accept decisions, pointer wrap (explicit compare so any depth works),
  // occupancy update and next-cycle outcome flags.
  always_comb begin
    rd_accept   = bus.rd_en && !empty;
    // A full FIFO still takes a write when a read frees a slot on the same edge.
    wr_accept   = bus.wr_en && (!full || rd_accept);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_accept;
    overflow_d  = bus.wr_en && !wr_accept;
    underflow_d = bus.rd_en && empty;
    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array: never cleared, only written by accepted writes.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is visible as soon as it is stored; stale when empty.
    assign bus.data_out = mem[rd_ptr_q];
  end else begin : g_reg
    logic [FIFO_WIDTH-1:0] dout_q, dout_d;

    // Load the head word on an accepted read, hold otherwise.
    always_comb begin
      dout_d = dout_q;
      if (rd_accept) dout_d = mem[rd_ptr_q];
    end

    // Registered read data, cleared by reset.
    always_ff @(posedge clk) begin
      if (rst) dout_q <= '0;
      else     dout_q <= dout_d;
    end

    assign bus.data_out = dout_q;
  end

  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = almostfull;
  assign bus.almostempty = almostempty;
  assign bus.count       = count_q;
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: a default registered-read FIFO (depth 8) and a
// depth-5 first-word-fall-through FIFO, both against a queue-based model.
module tb_fifo_param;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) if0 ();
  fifo_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) if1 ();

  fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_MARGIN(1), .AE_MARGIN(2), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_dout0 = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check0(input bit ack, input bit ovf, input bit udf);
    int n;
    n = exp_q0.size();
    chk("count0",  32'(if0.count), 32'(n));
    chk("full0",   32'(if0.full), 32'(n == 8));
    chk("empty0",  32'(if0.empty), 32'(n == 0));
    chk("afull0",  32'(if0.almostfull), 32'(n >= 7 && n != 8));
    chk("aempty0", 32'(if0.almostempty), 32'(n <= 1 && n != 0));
    chk("wr_ack0", 32'(if0.wr_ack), 32'(ack));
    chk("ovf0",    32'(if0.overflow), 32'(ovf));
    chk("udf0",    32'(if0.underflow), 32'(udf));
    chk("dout0",   32'(if0.data_out), 32'(exp_dout0));
  endtask

  task automatic check1(input bit ack, input bit ovf, input bit udf);
    int n;
    n = exp_q1.size();
    chk("count1",  32'(if1.count), 32'(n));
    chk("full1",   32'(if1.full), 32'(n == 5));
    chk("empty1",  32'(if1.empty), 32'(n == 0));
    chk("afull1",  32'(if1.almostfull), 32'(n >= 4 && n != 5));
    chk("aempty1", 32'(if1.almostempty), 32'(n <= 2 && n != 0));
    chk("wr_ack1", 32'(if1.wr_ack), 32'(ack));
    chk("ovf1",    32'(if1.overflow), 32'(ovf));
    chk("udf1",    32'(if1.underflow), 32'(udf));
    if (n > 0) chk("dout1", 32'(if1.data_out), 32'(exp_q1[0]));
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    if0.wr_en = 1'b0; if0.rd_en = 1'b0; if0.data_in = 16'h0;
    if1.wr_en = 1'b0; if1.rd_en = 1'b0; if1.data_in = 16'h0;
  endtask

  task automatic do_reset(input bit wr_during);
    rst = 1'b1;
    if0.wr_en = wr_during; if0.data_in = 16'h5555;
    if1.wr_en = wr_during; if1.data_in = 16'h6666;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    exp_q0.delete();
    exp_q1.delete();
    exp_dout0 = 16'h0;
    check0(1'b0, 1'b0, 1'b0);
    check1(1'b0, 1'b0, 1'b0);
  endtask

  task automatic step0(input bit wr, input bit rd, input logic [15:0] d);
    int n;
    bit rd_ok, wr_ok;
    n = exp_q0.size();
    rd_ok = rd && (n > 0);
    wr_ok = wr && ((n < 8) || rd_ok);
    if0.wr_en = wr; if0.rd_en = rd; if0.data_in = d;
    @(posedge clk); #1;
    if (rd_ok) exp_dout0 = exp_q0.pop_front();
    if (wr_ok) exp_q0.push_back(d);
    if0.wr_en = 1'b0; if0.rd_en = 1'b0;
    check0(wr_ok, wr && !wr_ok, rd && (n == 0));
  endtask

  task automatic step1(input bit wr, input bit rd, input logic [15:0] d);
    int n;
    bit rd_ok, wr_ok;
    n = exp_q1.size();
    rd_ok = rd && (n > 0);
    wr_ok = wr && ((n < 5) || rd_ok);
    if1.wr_en = wr; if1.rd_en = rd; if1.data_in = d;
    @(posedge clk); #1;
    if (rd_ok) void'(exp_q1.pop_front());
    if (wr_ok) exp_q1.push_back(d);
    if1.wr_en = 1'b0; if1.rd_en = 1'b0;
    check1(wr_ok, wr && !wr_ok, rd && (n == 0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    do_reset(1'b0);

    // Fill 0x0001..0x0008, then write to full (dropped), then drain.
    for (int i = 1; i <= 8; i++) step0(1'b1, 1'b0, 16'(i));
    step0(1'b1, 1'b0, 16'hDEAD);
    for (int i = 0; i < 8; i++) step0(1'b0, 1'b1, 16'h0);

    // Simultaneous read/write while full, then drain ending with 0x00AA.
    for (int i = 1; i <= 8; i++) step0(1'b1, 1'b0, 16'(i));
    step0(1'b1, 1'b1, 16'h00AA);
    for (int i = 0; i < 8; i++) step0(1'b0, 1'b1, 16'h0);

    // Read while empty, then read+write while empty.
    step0(1'b0, 1'b1, 16'h0);
    step0(1'b1, 1'b1, 16'h0BEE);
    step0(1'b0, 1'b1, 16'h0);

    // Reset mid-operation with a write pending.
    for (int i = 0; i < 5; i++) step0(1'b1, 1'b0, 16'h0300 + 16'(i));
    do_reset(1'b1);

    // Randomized traffic with phases biased toward full and toward empty.
    for (int i = 0; i < 300; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 75 : 25;
      step0($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
            16'($urandom_range(0, 65535)));
    end

    // FWFT depth 5: 12 interleaved writes/reads across the pointer wrap.
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) step1(1'b1, (i % 2) == 1, 16'h0100 + 16'(i));
    for (int i = 0; i < 8; i++) step1(1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 6; i++) step1(1'b1, 1'b0, 16'h0200 + 16'(i));
    step1(1'b1, 1'b1, 16'h02AA);
    for (int i = 0; i < 200; i++) begin
      step1($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
            16'($urandom_range(0, 65535)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
